// File: rtl/mod_mul_ctrl.sv
// Sequential modular multiplier: oData = (iA * iB) mod iQ, MSB-first double-and-add with a start/done handshake.
// Optional MOD_MUL_CTRL_EARLY_EXIT_EN: start at the leading one of iB so leading zeros cost no cycles.

// Combinational 2*x mod q, for x < q.
module mod_mul_dbl #(
    parameter int BITWIDTH = 8
) (
    input  logic [BITWIDTH-1:0] x,
    input  logic [BITWIDTH-1:0] q,
    output logic [BITWIDTH-1:0] y
);
    logic [BITWIDTH:0] dbl;
    logic [BITWIDTH:0] dblSub;

    always_comb begin
        dbl    = {x, 1'b0};
        dblSub = dbl - {1'b0, q};
        y      = (dbl >= {1'b0, q}) ? dblSub[BITWIDTH-1:0] : dbl[BITWIDTH-1:0];
    end
endmodule

// Combinational (x + a) mod q, for x < q and a < q.
module mod_mul_add #(
    parameter int BITWIDTH = 8
) (
    input  logic [BITWIDTH-1:0] x,
    input  logic [BITWIDTH-1:0] a,
    input  logic [BITWIDTH-1:0] q,
    output logic [BITWIDTH-1:0] y
);
    logic [BITWIDTH:0] sum;
    logic [BITWIDTH:0] sumSub;

    always_comb begin
        sum    = {1'b0, x} + {1'b0, a};
        sumSub = sum - {1'b0, q};
        y      = (sum >= {1'b0, q}) ? sumSub[BITWIDTH-1:0] : sum[BITWIDTH-1:0];
    end
endmodule

// state | meaning
// IDLE  | oReady=1, waiting for iStart
// RUN   | one double-and-add step per enabled edge, idx counts down to 0
// DONE  | oValid=1, oData holds the product until iAck
module mod_mul_ctrl #(
    parameter int BITWIDTH = 8
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic                iEn,
    input  logic                iClr,
    input  logic                iStart,
    output logic                oReady,
    input  logic [BITWIDTH-1:0] iA,
    input  logic [BITWIDTH-1:0] iB,
    input  logic [BITWIDTH-1:0] iQ,
    output logic [BITWIDTH-1:0] oData,
    output logic                oValid,
    input  logic                iAck
);
    localparam int IW = (BITWIDTH > 1) ? $clog2(BITWIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state;
    logic [BITWIDTH-1:0] regA;
    logic [BITWIDTH-1:0] regB;
    logic [BITWIDTH-1:0] regQ;
    logic [BITWIDTH-1:0] acc;
    logic [IW-1:0]       idx;

    logic [BITWIDTH-1:0] dblMod;
    logic [BITWIDTH-1:0] addMod;
    logic [BITWIDTH-1:0] stepRes;
    logic [IW-1:0]       startIdx;
    logic                bZero;

    mod_mul_dbl #(.BITWIDTH(BITWIDTH)) uDbl (
        .x(acc),
        .q(regQ),
        .y(dblMod)
    );

    mod_mul_add #(.BITWIDTH(BITWIDTH)) uAdd (
        .x(dblMod),
        .a(regA),
        .q(regQ),
        .y(addMod)
    );

    assign stepRes = regB[idx] ? addMod : dblMod;

`ifdef MOD_MUL_CTRL_EARLY_EXIT_EN
    // Leading-one detector on the live iB; only used on the accept edge.
    always_comb begin
        startIdx = '0;
        bZero    = (iB == '0);
        for (int i = 0; i < BITWIDTH; i++) begin
            if (iB[i]) startIdx = IW'(i);
        end
    end
`else
    assign startIdx = IW'(BITWIDTH - 1);
    assign bZero    = 1'b0;
`endif

    always_ff @(posedge iClk) begin
        if (iRst || iClr) begin
            state  <= IDLE;
            regA   <= '0;
            regB   <= '0;
            regQ   <= '0;
            acc    <= '0;
            idx    <= IW'(BITWIDTH - 1);
            oData  <= '0;
            oValid <= 1'b0;
            oReady <= 1'b1;
        end else if (iEn) begin
            case (state)
                IDLE: begin
                    if (iStart) begin
                        regA   <= iA;
                        regB   <= iB;
                        regQ   <= iQ;
                        acc    <= '0;
                        idx    <= startIdx;
                        oReady <= 1'b0;
                        if (bZero) begin
                            state  <= DONE;
                            oData  <= '0;
                            oValid <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    acc <= stepRes;
                    if (idx == '0) begin
                        state  <= DONE;
                        oData  <= stepRes;
                        oValid <= 1'b1;
                    end else begin
                        idx <= idx - IW'(1);
                    end
                end
                DONE: begin
                    if (iAck) begin
                        state  <= IDLE;
                        oValid <= 1'b0;
                        oReady <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    oValid <= 1'b0;
                    oReady <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mod_mul_ctrl.sv
// Scoreboard bench for mod_mul_ctrl: driver pushes expected product and latency, monitor checks on each oValid rise.
module tb_mod_mul_ctrl;
    logic       iClk;
    logic       iRst;
    logic       iEn;
    logic       iClr;
    logic       iStart;
    logic       oReady;
    logic [7:0] iA;
    logic [7:0] iB;
    logic [7:0] iQ;
    logic [7:0] oData;
    logic       oValid;
    logic       iAck;

    typedef struct {
        logic [7:0] data;
        int         lat;
        int         acc;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic prevValid = 1'b0;

    mod_mul_ctrl #(.BITWIDTH(8)) dut (
        .iClk(iClk), .iRst(iRst), .iEn(iEn), .iClr(iClr), .iStart(iStart),
        .oReady(oReady), .iA(iA), .iB(iB), .iQ(iQ), .oData(oData),
        .oValid(oValid), .iAck(iAck)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    always @(posedge iClk) cyc <= cyc + 1;

    function automatic int expLat(logic [7:0] b);
        int m;
        m = 0;
`ifdef MOD_MUL_CTRL_EARLY_EXIT_EN
        if (b == 8'd0) return 1;
        for (int i = 0; i < 8; i++) if (b[i]) m = i;
        return m + 1;
`else
        m = b[0] ? 8 : 8;
        return m;
`endif
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every rising oValid must match the oldest outstanding expectation.
    always @(negedge iClk) begin
        if (oValid === 1'b1 && prevValid !== 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got oValid=1 oData=%0d expected no result", oData);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("sb_data", int'(oData), int'(e.data));
                chk("sb_latency", cyc - e.acc, e.lat);
                chk("sb_ready_low", int'(oReady), 0);
            end
        end
        prevValid = oValid;
    end

    task automatic startOp(input logic [7:0] a, input logic [7:0] b, input logic [7:0] q,
                           input bit push, input logic [7:0] data, input int extra);
        exp_t e;
        @(negedge iClk);
        iA = a;
        iB = b;
        iQ = q;
        iStart = 1'b1;
        @(negedge iClk);
        iStart = 1'b0;
        if (push) begin
            e.data = data;
            e.lat  = expLat(b) + extra;
            e.acc  = cyc;
            sbq.push_back(e);
        end
    endtask

    task automatic waitValid(string name);
        int n;
        n = 0;
        while (oValid !== 1'b1 && n < 40) begin
            @(negedge iClk);
            n++;
        end
        if (oValid !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no oValid in 40 cycles expected oValid=1", name);
        end
    endtask

    logic [7:0] sweepA [5] = '{8'd10, 8'd10, 8'd10, 8'd22, 8'd254};
    logic [7:0] sweepB [5] = '{8'd13, 8'd13, 8'd13, 8'd255, 8'd254};
    logic [7:0] sweepQ [5] = '{8'd17, 8'd23, 8'd14, 8'd23, 8'd255};
    logic [7:0] sweepR [5] = '{8'd11, 8'd15, 8'd4, 8'd21, 8'd1};

    initial begin
        iRst = 1'b1; iEn = 1'b1; iClr = 1'b0; iStart = 1'b0; iAck = 1'b1;
        iA = '0; iB = '0; iQ = 8'd2;
        repeat (3) @(negedge iClk);
        iRst = 1'b0;
        chk("reset_ready", int'(oReady), 1);
        chk("reset_valid", int'(oValid), 0);
        chk("reset_data", int'(oData), 0);

        // Basic product and return to IDLE.
        startOp(8'd10, 8'd2, 8'd23, 1'b1, 8'd20, 0);
        waitValid("basic");
        @(negedge iClk);
        chk("basic_ready_after_ack", int'(oReady), 1);
        chk("basic_valid_after_ack", int'(oValid), 0);

        for (int i = 0; i < 5; i++) begin
            startOp(sweepA[i], sweepB[i], sweepQ[i], 1'b1, sweepR[i], 0);
            waitValid("sweep");
            @(negedge iClk);
        end

        // Stall three cycles mid-RUN, then backpressure.
        iAck = 1'b0;
        startOp(8'd10, 8'd13, 8'd17, 1'b1, 8'd11, 3);
        repeat (2) @(negedge iClk);
        iEn = 1'b0;
        repeat (3) @(negedge iClk);
        iEn = 1'b1;
        waitValid("stall");
        repeat (5) begin
            @(negedge iClk);
            chk("hold_valid", int'(oValid), 1);
            chk("hold_data", int'(oData), 11);
        end
        iAck = 1'b1;
        @(negedge iClk);
        chk("ack_valid", int'(oValid), 0);
        chk("ack_ready", int'(oReady), 1);
        chk("idle_data_held", int'(oData), 11);

        // Abort at the fourth RUN edge.
        startOp(8'd10, 8'd13, 8'd17, 1'b0, 8'd0, 0);
        repeat (3) @(negedge iClk);
        iClr = 1'b1;
        @(negedge iClk);
        iClr = 1'b0;
        chk("clr_ready", int'(oReady), 1);
        chk("clr_valid", int'(oValid), 0);
        chk("clr_data", int'(oData), 0);
        repeat (12) @(negedge iClk);
        chk("clr_no_valid", int'(oValid), 0);
        startOp(8'd3, 8'd5, 8'd7, 1'b1, 8'd1, 0);
        waitValid("restart");
        @(negedge iClk);

        // Input isolation: operand changes and iStart during RUN are ignored.
        iAck = 1'b0;
        startOp(8'd10, 8'd13, 8'd17, 1'b1, 8'd11, 0);
        iA = 8'd200; iB = 8'd255; iQ = 8'd250;
        @(negedge iClk);
        iStart = 1'b1;
        @(negedge iClk);
        iStart = 1'b0;
        waitValid("isolation");
        chk("iso_data", int'(oData), 11);
        iAck = 1'b1;
        @(negedge iClk);
        chk("iso_valid_after_ack", int'(oValid), 0);
        repeat (15) @(negedge iClk);
        chk("iso_no_queue", int'(oReady), 1);

        // Reset while holding a result in DONE.
        iAck = 1'b0;
        startOp(8'd10, 8'd13, 8'd17, 1'b1, 8'd11, 0);
        waitValid("rst_done");
        iRst = 1'b1;
        @(negedge iClk);
        iRst = 1'b0;
        iAck = 1'b1;
        chk("rst_valid", int'(oValid), 0);
        chk("rst_ready", int'(oReady), 1);
        chk("rst_data", int'(oData), 0);

        // Leading-zero cases (latency depends on build).
        startOp(8'd7, 8'd0, 8'd23, 1'b1, 8'd0, 0);
        waitValid("bzero");
        @(negedge iClk);
        startOp(8'd5, 8'd1, 8'd7, 1'b1, 8'd5, 0);
        waitValid("bone");
        @(negedge iClk);
        startOp(8'd10, 8'd128, 8'd23, 1'b1, 8'd15, 0);
        waitValid("bmsb");
        @(negedge iClk);

        repeat (5) @(negedge iClk);
        chk("sb_drained", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
